// File: rtl/bcd_calc_pkg.sv
// Shared constants and state encoding for the calculator operand-entry
// BCD-to-binary converter.
package bcd_calc_pkg;

  // Default accumulator width (iterations) and largest S9-representable magnitude
  localparam int BIN_W_DEF   = 10;
  localparam int MAX_MAG_DEF = 255;

  // Largest legal BCD digit
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Reverse double-dabble correction: nibbles >= 8 after a right shift lose 3
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_nibble_adj.sv
// One BCD nibble correction step for reverse double-dabble:
// after the right shift, a nibble >= 8 had a "ten" carried in as 8,
// so subtracting 3 turns it back into the correct 5.
module bcd_nibble_adj
  import bcd_calc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  // Conditional subtract-3
  always_comb begin
    adjusted = nibble;
    if (nibble >= ADJ_THRESH) adjusted = nibble - ADJ_VAL;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: three BCD digits plus a sign are
// converted one bit per clock and presented as an unsigned magnitude and
// a 9-bit sign + two's-complement word matching the adder/subtractor.
module bcd_to_bin_seq
  import bcd_calc_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int MAX_MAG = MAX_MAG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       bcd_hund,
  input  logic [3:0]       bcd_tens,
  input  logic [3:0]       bcd_ones,
  input  logic             negative,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin_mag,
  output logic [8:0]       S9,
  output logic             err_digit,
  output logic             err_range
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t state, state_next;

  logic [11:0]      bcd_reg;
  logic [BIN_W-1:0] acc;
  logic             sign_reg;
  logic [CNT_W-1:0] cnt;

  logic [11:0]      bcd_shift;
  logic [11:0]      bcd_adj;
  logic [BIN_W-1:0] acc_shift;
  logic             digit_bad;
  logic             last_iter;
  logic             accept;

  // Magnitude too large for the 8-bit two's-complement field
  function automatic logic range_over(input logic [BIN_W-1:0] mag);
    return mag > BIN_W'(MAX_MAG);
  endfunction

  // Pack magnitude and sign into S9; out-of-range and negative zero give 0
  function automatic logic [8:0] s9_fmt(input logic [BIN_W-1:0] mag,
                                        input logic neg, input logic over);
    logic signed [7:0] neg_low;
    neg_low = -$signed(mag[7:0]);
    if (over)                  return 9'd0;
    else if (neg && mag != '0) return {1'b1, neg_low};
    else                       return {1'b0, mag[7:0]};
  endfunction

  assign digit_bad = (bcd_hund > DIGIT_MAX) || (bcd_tens > DIGIT_MAX) ||
                     (bcd_ones > DIGIT_MAX);
  assign accept    = (state == IDLE) && start;
  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  // {bcd_reg, acc} shifted right as one word: BCD LSB enters the acc MSB
  assign bcd_shift = bcd_reg >> 1;
  assign acc_shift = {bcd_reg[0], acc[BIN_W-1:1]};

  bcd_nibble_adj u_adj_ones (.nibble(bcd_shift[3:0]),   .adjusted(bcd_adj[3:0]));
  bcd_nibble_adj u_adj_tens (.nibble(bcd_shift[7:4]),   .adjusted(bcd_adj[7:4]));
  bcd_nibble_adj u_adj_hund (.nibble(bcd_shift[11:8]),  .adjusted(bcd_adj[11:8]));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = digit_bad ? DONE : CONV;
      CONV:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers CONV and the DONE cycle, done is the DONE cycle
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Iteration counter, cleared whenever idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == CONV)  cnt <= cnt + CNT_W'(1);
    else if (state == IDLE)  cnt <= '0;
  end

  // Conversion datapath: capture on accept, shift-and-adjust while converting
  always_ff @(posedge clk) begin
    if (accept) begin
      bcd_reg  <= {bcd_hund, bcd_tens, bcd_ones};
      acc      <= '0;
      sign_reg <= negative;
    end else if (state == CONV) begin
      bcd_reg  <= bcd_adj;
      acc      <= acc_shift;
    end
  end

  // Result registers, loaded on entry to DONE and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_mag   <= '0;
      S9        <= '0;
      err_digit <= 1'b0;
      err_range <= 1'b0;
    end else if (accept && digit_bad) begin
      bin_mag   <= '0;
      S9        <= '0;
      err_digit <= 1'b1;
      err_range <= 1'b0;
    end else if (state == CONV && last_iter) begin
      bin_mag   <= acc_shift;
      S9        <= s9_fmt(acc_shift, sign_reg, range_over(acc_shift));
      err_digit <= 1'b0;
      err_range <= range_over(acc_shift);
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: directed table, hand-written multi-cycle
// sequences, and randomized digits against an arithmetic reference model.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       negative;
  logic       busy, done;
  logic [9:0] bin_mag;
  logic [8:0] S9;
  logic       err_digit, err_range;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_mag = 0;
  int prev_s9  = 0;

  typedef struct {
    int h, t, o;
    bit neg;
    int mag, s9, er, ed;
  } vec_t;

  vec_t tbl[11];

  bcd_to_bin_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .negative(negative), .busy(busy), .done(done), .bin_mag(bin_mag),
    .S9(S9), .err_digit(err_digit), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: decimal value by plain arithmetic, S9 as sign + low byte of -value
  function automatic void model(input int h, input int t, input int o, input bit neg,
                                output int mag, output int s9, output int er, output int ed);
    ed = (h > 9 || t > 9 || o > 9) ? 1 : 0;
    if (ed == 1) begin
      mag = 0; s9 = 0; er = 0;
    end else begin
      mag = h * 100 + t * 10 + o;
      er  = (mag > 255) ? 1 : 0;
      if (er == 1)                s9 = 0;
      else if (neg && mag != 0)   s9 = 256 + ((256 - mag) % 256);
      else                        s9 = mag;
    end
  endfunction

  task automatic wait_done(input int limit, inout int cyc);
    while (!done && cyc < limit) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run_conv(input int h, input int t, input int o, input bit neg,
                          input int mag, input int s9, input int er, input int ed,
                          input string tag);
    int lat = (ed == 1) ? 1 : 11;
    int cyc = 1;
    int busy_cnt = 0;
    int hold_ok = 1;
    @(posedge clk); #1;
    start = 1'b1;
    bcd_hund = 4'(h); bcd_tens = 4'(t); bcd_ones = 4'(o); negative = neg;
    @(posedge clk); #1;
    start = 1'b0;
    bcd_hund = 4'($urandom); bcd_tens = 4'($urandom);
    bcd_ones = 4'($urandom); negative = 1'($urandom);
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (int'(bin_mag) != prev_mag || int'(S9) != prev_s9) hold_ok = 0;
      @(posedge clk); #1; cyc++;
    end
    if (busy) busy_cnt++;
    check({tag, ".latency"}, cyc, lat);
    check({tag, ".busy_cycles"}, busy_cnt, lat);
    check({tag, ".hold_during_conv"}, hold_ok, 1);
    check({tag, ".bin_mag"}, int'(bin_mag), mag);
    check({tag, ".S9"}, int'(S9), s9);
    check({tag, ".err_range"}, int'(err_range), er);
    check({tag, ".err_digit"}, int'(err_digit), ed);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, int'(done), 0);
    check({tag, ".busy_after"}, int'(busy), 0);
    check({tag, ".mag_hold"}, int'(bin_mag), mag);
    prev_mag = mag;
    prev_s9  = s9;
  endtask

  initial begin
    int cyc;
    int saw_done;
    int mag, s9, er, ed, h, t, o;
    bit neg;

    tbl[0]  = '{1, 2, 3, 1'b0, 123, 'h07B, 0, 0};
    tbl[1]  = '{1, 2, 8, 1'b1, 128, 'h180, 0, 0};
    tbl[2]  = '{2, 5, 5, 1'b1, 255, 'h101, 0, 0};
    tbl[3]  = '{0, 0, 0, 1'b1, 0,   'h000, 0, 0};
    tbl[4]  = '{9, 9, 9, 1'b0, 999, 'h000, 1, 0};
    tbl[5]  = '{10, 0, 0, 1'b0, 0,  'h000, 0, 1};
    tbl[6]  = '{2, 5, 6, 1'b0, 256, 'h000, 1, 0};
    tbl[7]  = '{0, 0, 1, 1'b1, 1,   'h1FF, 0, 0};
    tbl[8]  = '{2, 5, 5, 1'b0, 255, 'h0FF, 0, 0};
    tbl[9]  = '{3, 0, 15, 1'b1, 0,  'h000, 0, 1};
    tbl[10] = '{0, 6, 4, 1'b1, 64,  'h1C0, 0, 0};

    rst_n = 1'b0; start = 1'b0; negative = 1'b0;
    bcd_hund = 4'd0; bcd_tens = 4'd0; bcd_ones = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.bin_mag", int'(bin_mag), 0);
    check("reset.S9", int'(S9), 0);
    check("reset.err_digit", int'(err_digit), 0);
    check("reset.err_range", int'(err_range), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_conv(tbl[i].h, tbl[i].t, tbl[i].o, tbl[i].neg,
               tbl[i].mag, tbl[i].s9, tbl[i].er, tbl[i].ed, $sformatf("tbl%0d", i));

    // Second start during conversion must be ignored
    @(posedge clk); #1;
    start = 1'b1; bcd_hund = 4'd0; bcd_tens = 4'd4; bcd_ones = 4'd2; negative = 1'b0;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; bcd_hund = 4'd9; bcd_tens = 4'd9; bcd_ones = 4'd9;
    @(posedge clk); #1; cyc++; start = 1'b0;
    wait_done(40, cyc);
    check("ignore.latency", cyc, 11);
    check("ignore.bin_mag", int'(bin_mag), 42);
    check("ignore.S9", int'(S9), 42);
    @(posedge clk); #1;
    check("ignore.idle_after", int'(busy), 0);
    prev_mag = 42; prev_s9 = 42;

    // start held high restarts in every IDLE cycle
    @(posedge clk); #1;
    start = 1'b1; bcd_hund = 4'd0; bcd_tens = 4'd0; bcd_ones = 4'd7; negative = 1'b1;
    @(posedge clk); #1; cyc = 1;
    wait_done(40, cyc);
    check("held.first_done", cyc, 11);
    check("held.S9", int'(S9), 'h1F9);
    @(posedge clk); #1; cyc++;
    wait_done(60, cyc);
    check("held.second_done", cyc, 23);
    start = 1'b0;
    @(posedge clk); #1;
    prev_mag = 7; prev_s9 = 'h1F9;

    run_conv(1, 0, 0, 1'b0, 100, 100, 0, 0, "pre_reset");

    // Asynchronous reset in cycle 6 of a conversion
    @(posedge clk); #1;
    start = 1'b1; bcd_hund = 4'd1; bcd_tens = 4'd2; bcd_ones = 4'd3; negative = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.bin_mag", int'(bin_mag), 0);
    check("midrst.S9", int'(S9), 0);
    saw_done = 0;
    repeat (2) begin @(posedge clk); #1; if (done) saw_done = 1; end
    rst_n = 1'b1;
    repeat (14) begin @(posedge clk); #1; if (done || busy) saw_done = 1; end
    check("midrst.no_done", saw_done, 0);
    prev_mag = 0; prev_s9 = 0;
    run_conv(2, 0, 0, 1'b0, 200, 200, 0, 0, "post_reset");

    // Randomized digits against the reference model
    for (int i = 0; i < 40; i++) begin
      h   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      t   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      o   = int'($urandom_range(0, 10));
      neg = 1'($urandom_range(0, 1));
      model(h, t, o, neg, mag, s9, er, ed);
      run_conv(h, t, o, neg, mag, s9, er, ed, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
